pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB, branch resolved in ID by the register-equality comparator). It detects load-use and branch-operand hazards, freezes the whole pipeline while a variable-latency data memory is busy, and generates the PC-select/flush controls for a taken beq. It drives the PC write enable, the IF/ID write/flush and the ID/EX bubble, and holds the downstream pipeline registers.

---
 rtl/pipeline_hazard_ctrl_if.sv | 41 ++++
 rtl/pipeline_hazard_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard inputs and pipeline stall/flush controls.
// The master modport is the pipeline datapath side; the slave modport is the controller.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic [4:0]       id_rs_addr_i;
  logic [4:0]       id_rt_addr_i;
  logic             id_uses_rt_i;
  logic             id_branch_i;
  logic             id_equal_i;
  logic             ex_reg_write_i;
  logic             ex_mem_read_i;
  logic [4:0]       ex_rd_addr_i;
  logic             mem_req_i;
  logic             mem_ack_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             pipe_hold_o;
  logic             pc_src_o;
  logic             mem_err_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output start_i, id_rs_addr_i, id_rt_addr_i, id_uses_rt_i, id_branch_i, id_equal_i,
           ex_reg_write_i, ex_mem_read_i, ex_rd_addr_i, mem_req_i, mem_ack_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o, pc_src_o,
           mem_err_o, state_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  start_i, id_rs_addr_i, id_rt_addr_i, id_uses_rt_i, id_branch_i, id_equal_i,
           ex_reg_write_i, ex_mem_read_i, ex_rd_addr_i, mem_req_i, mem_ack_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o, pc_src_o,
           mem_err_o, state_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline with ID-stage branch resolution.
// Optional perf counters are built when HAZARD_PERF_EN is defined; otherwise they read 0.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input logic                  clk_i,
  input logic                  rst_i,
  pipeline_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, MEM_WAIT = 2'd2, ERR = 2'd3} state_t;
  typedef enum logic [1:0] {M_GO, M_STALL, M_FREEZE, M_FLUSH} mode_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_nxt;
  logic       rem_q, rem_nxt;
  logic [7:0] wait_q, wait_nxt;
  logic       err_q, err_nxt;
  mode_t      mode;

  logic       ex_hit, load_hit, alu_hit, busy;
  logic [1:0] stall_n;

  // $0 is hard-wired zero, so a write to it can never create a dependency.
  assign ex_hit = (bus.ex_rd_addr_i != 5'd0) &&
                  ((bus.ex_rd_addr_i == bus.id_rs_addr_i) ||
                   (bus.id_uses_rt_i && bus.ex_rd_addr_i == bus.id_rt_addr_i));
  assign load_hit = bus.ex_mem_read_i && ex_hit;
  assign alu_hit  = bus.ex_reg_write_i && !bus.ex_mem_read_i && ex_hit;
  assign busy     = bus.mem_req_i && !bus.mem_ack_i;

  always_comb begin
    stall_n = 2'd0;
    if (load_hit)
      stall_n = bus.id_branch_i ? 2'd2 : 2'd1;
    else if (alu_hit && bus.id_branch_i)
      stall_n = 2'd1;
  end

  always_comb begin
    state_nxt = state_q;
    rem_nxt   = rem_q;
    wait_nxt  = wait_q;
    err_nxt   = err_q;
    mode      = M_GO;
    if (rst_i || !bus.start_i) begin
      mode = M_FREEZE;
    end else begin
      case (state_q)
        RUN: begin
          if (busy) begin
            mode      = M_FREEZE;
            wait_nxt  = 8'd0;
            state_nxt = MEM_WAIT;
          end else if (stall_n != 2'd0) begin
            mode = M_STALL;
            if (stall_n == 2'd2) begin
              rem_nxt   = 1'b1;
              state_nxt = STALL;
            end
          end else if (bus.id_branch_i && bus.id_equal_i) begin
            mode = M_FLUSH;
          end
        end
        STALL: begin
          // A frozen cycle does not consume the pending stall.
          if (busy) begin
            mode      = M_FREEZE;
            wait_nxt  = 8'd0;
            state_nxt = MEM_WAIT;
          end else begin
            mode      = M_STALL;
            rem_nxt   = 1'b0;
            state_nxt = RUN;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ack_i) begin
            mode      = M_GO;
            wait_nxt  = 8'd0;
            state_nxt = rem_q ? STALL : RUN;
          end else begin
            mode = M_FREEZE;
            if (wait_q == WAIT_LAST) begin
              err_nxt   = 1'b1;
              state_nxt = ERR;
            end else begin
              wait_nxt = wait_q + 8'd1;
            end
          end
        end
        default: mode = M_FREEZE;
      endcase
    end
  end

  always_comb begin
    bus.pc_write_o    = 1'b1;
    bus.ifid_write_o  = 1'b1;
    bus.ifid_flush_o  = 1'b0;
    bus.idex_bubble_o = 1'b0;
    bus.pipe_hold_o   = 1'b0;
    bus.pc_src_o      = 1'b0;
    case (mode)
      M_STALL: begin
        bus.pc_write_o    = 1'b0;
        bus.ifid_write_o  = 1'b0;
        bus.idex_bubble_o = 1'b1;
      end
      M_FREEZE: begin
        bus.pc_write_o   = 1'b0;
        bus.ifid_write_o = 1'b0;
        bus.pipe_hold_o  = 1'b1;
      end
      M_FLUSH: begin
        bus.pc_src_o     = 1'b1;
        bus.ifid_flush_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      rem_q   <= 1'b0;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      rem_q   <= rem_nxt;
      wait_q  <= wait_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.mem_err_o = err_q;
  assign bus.state_o   = state_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.start_i && !bus.pc_write_o && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (bus.ifid_flush_o && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
`else
  assign bus.stall_cnt_o = '0;
  assign bus.flush_cnt_o = '0;
`endif
endmodule
